regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the core's integer register file: 1 write port, 2 synchronous read ports, configurable width/depth.
- Adds an optional hardwired-zero register, optional write-to-read forwarding, a read-enable hold and a per-register pending-write scoreboard.
- Sits in the decode stage: read data and hazard flags are registered and feed the execute stage.
- Writeback and issue logic drive the write and scoreboard ports.

Parameters:
- DATA_W, 32, data width of each register.
- ADDR_W, 5, width of all register address ports.
- DEPTH, 32, number of implemented registers; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 always reads 0 and is never written or marked busy.
- BYPASS, 1, 1 = same-edge write is forwarded to the read outputs; 0 = reads return the pre-write value.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- reg_wr  in  1  write enable (writeback)
- wr_reg  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  read enable; 0 holds both read outputs and both hazard flags
- re_reg1  in  ADDR_W  read address, port 1
- re_reg2  in  ADDR_W  read address, port 2
- re_data1  out  DATA_W  registered read data, port 1
- re_data2  out  DATA_W  registered read data, port 2
- issue_valid  in  1  an instruction issued that will write issue_reg
- issue_reg  in  ADDR_W  destination of the issued instruction
- hazard1  out  1  registered: the port 1 source was pending at sample time
- hazard2  out  1  registered: the port 2 source was pending at sample time
- busy_vec  out  DEPTH  current scoreboard bits (combinational view of state)

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - all registers, re_data1/2, hazard1/2 and busy_vec go to 0 immediately.
  - they hold 0 while reset is low; the first edge after release behaves normally.
  - a write or issue in progress is lost.
- Write: at posedge, if reg_wr=1 and wr_reg < DEPTH and not (ZERO_REG=1 and wr_reg=0), then mem[wr_reg] <= wr_data. Otherwise no state change.
- Read latency is 1 cycle. At posedge with rd_en=1, for each port n:
  - addr >= DEPTH, or (ZERO_REG=1 and addr=0): re_datan <= 0.
  - BYPASS=1 and a valid write targets addr on the same edge: re_datan <= wr_data.
  - otherwise re_datan <= mem[addr] (old value).
  - with rd_en=0, re_datan and hazardn hold their values.
- Both ports may read the same address. Each applies the rules independently.
- Scoreboard, for valid addresses only:
  - issue_valid=1 sets busy[issue_reg].
  - a valid write clears busy[wr_reg].
  - issue and write to the same register on the same edge: set wins (newer producer).
  - issue to register 0 with ZERO_REG=1, or to an address >= DEPTH, is ignored.
  - a write to a non-busy register is legal and leaves busy at 0.
- Hazard flags: at posedge with rd_en=1, hazardn <= busy[addr] evaluated before this edge's update, with two exceptions:
  - if BYPASS=1 and this edge's write clears that register, hazardn <= 0.
  - an issue on the same edge does not raise hazardn; it affects the next read.
  - invalid or zero-register addresses give hazardn <= 0.
- Widths: no truncation or extension of data.
- Address compare uses the full ADDR_W bits.
- The range check is elided when DEPTH = 2**ADDR_W.

Test Plan:
- Reset, then write 0xDEADBEEF to r5. Next edge: read r5 on both ports -> re_data1 = re_data2 = 0xDEADBEEF one cycle after the addresses are presented. Assert reset mid-run -> outputs 0 immediately, without a clock edge.
- ZERO_REG=1: write 0x12345678 to r0, then read r0 -> 0; issue to r0 -> busy_vec[0] stays 0, hazard 0.
- Same-edge write 0xA5A5A5A5 to r7 and read r7 (old value 0x1):
  - BYPASS=1 -> re_data1 = 0xA5A5A5A5.
  - BYPASS=0 -> re_data1 = 0x1, then 0xA5A5A5A5 on the following read.
- Scoreboard sequence:
  - issue r3, then read r3 -> hazard1 = 1.
  - writeback r3 on the same edge as a read -> hazard1 = 0 (BYPASS=1) with forwarded data.
  - same-edge issue and write to r3 -> busy_vec[3] = 1.
- DEPTH=16, ADDR_W=5:
  - write to r20 -> ignored.
  - read r20 -> 0, hazard 0.
  - issue r20 -> busy_vec unchanged.
- rd_en=0 for 3 cycles while addresses and memory change -> re_data1/2 and hazard1/2 hold their last values. rd_en=1 -> they update on the next edge.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised 1W/2R register file with optional zero register, write forwarding and pending-write scoreboard.
// Reads and hazard flags are registered (1 cycle); rd_en=0 holds them, no backpressure otherwise.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_wr,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] re_reg1,
  input  logic [ADDR_W-1:0] re_reg2,
  output logic [DATA_W-1:0] re_data1,
  output logic [DATA_W-1:0] re_data2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              hazard1,
  output logic              hazard2,
  output logic [DEPTH-1:0]  busy_vec
);

  // When every address maps to a register the range compare is constant-true.
  localparam bit              FULL    = (DEPTH == (1 << ADDR_W));
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  logic              wr_ok;
  logic              iss_ok;
  logic              ok1;
  logic              ok2;
  logic              fwd1;
  logic              fwd2;
  logic [DATA_W-1:0] mem_rd1;
  logic [DATA_W-1:0] mem_rd2;
  logic              busy_rd1;
  logic              busy_rd2;
  logic [DATA_W-1:0] data_nxt1;
  logic [DATA_W-1:0] data_nxt2;
  logic              haz_nxt1;
  logic              haz_nxt2;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return FULL ? 1'b1 : ({1'b0, a} < DEPTH_L);
  endfunction

  function automatic logic usable(input logic [ADDR_W-1:0] a);
    return in_range(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok  = reg_wr && usable(wr_reg);
  assign iss_ok = issue_valid && usable(issue_reg);
  assign ok1    = usable(re_reg1);
  assign ok2    = usable(re_reg2);
  assign fwd1   = (BYPASS != 0) && wr_ok && (wr_reg == re_reg1);
  assign fwd2   = (BYPASS != 0) && wr_ok && (wr_reg == re_reg2);

  // Decoded read muxes; out-of-range addresses simply match nothing.
  always_comb begin
    mem_rd1  = '0;
    mem_rd2  = '0;
    busy_rd1 = 1'b0;
    busy_rd2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (re_reg1 == ADDR_W'(i)) begin
        mem_rd1  = mem[i];
        busy_rd1 = busy[i];
      end
      if (re_reg2 == ADDR_W'(i)) begin
        mem_rd2  = mem[i];
        busy_rd2 = busy[i];
      end
    end
  end

  always_comb begin
    data_nxt1 = '0;
    data_nxt2 = '0;
    if (ok1) data_nxt1 = fwd1 ? wr_data : mem_rd1;
    if (ok2) data_nxt2 = fwd2 ? wr_data : mem_rd2;
    haz_nxt1 = ok1 && !fwd1 && busy_rd1;
    haz_nxt2 = ok2 && !fwd2 && busy_rd2;
  end

  // Issue is applied after writeback so a newer producer keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (wr_reg == ADDR_W'(i)))       busy_nxt[i] = 1'b0;
      if (iss_ok && (issue_reg == ADDR_W'(i)))   busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && (wr_reg == ADDR_W'(i))) mem[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      re_data1 <= '0;
      re_data2 <= '0;
      hazard1  <= 1'b0;
      hazard2  <= 1'b0;
    end else if (rd_en) begin
      re_data1 <= data_nxt1;
      re_data2 <= data_nxt2;
      hazard1  <= haz_nxt1;
      hazard2  <= haz_nxt2;
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_param.sv
// Drives three configurations (default, no-forwarding, DEPTH=16) with shared stimulus
// and compares each against an array-based reference model plus a hand-computed vector table.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_wr;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [4:0]  re_reg1;
  logic [4:0]  re_reg2;
  logic        issue_valid;
  logic [4:0]  issue_reg;

  logic [31:0] d1 [3];
  logic [31:0] d2 [3];
  logic        h1 [3];
  logic        h2 [3];
  logic [31:0] bv [3];
  logic [31:0] bv_a;
  logic [31:0] bv_b;
  logic [15:0] bv_c;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clk(clk), .reset(reset), .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_en(rd_en), .re_reg1(re_reg1), .re_reg2(re_reg2),
    .re_data1(d1[0]), .re_data2(d2[0]), .issue_valid(issue_valid), .issue_reg(issue_reg),
    .hazard1(h1[0]), .hazard2(h2[0]), .busy_vec(bv_a));

  regfile_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
    .clk(clk), .reset(reset), .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_en(rd_en), .re_reg1(re_reg1), .re_reg2(re_reg2),
    .re_data1(d1[1]), .re_data2(d2[1]), .issue_valid(issue_valid), .issue_reg(issue_reg),
    .hazard1(h1[1]), .hazard2(h2[1]), .busy_vec(bv_b));

  regfile_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .ZERO_REG(1), .BYPASS(1)) u_dut_c (
    .clk(clk), .reset(reset), .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_en(rd_en), .re_reg1(re_reg1), .re_reg2(re_reg2),
    .re_data1(d1[2]), .re_data2(d2[2]), .issue_valid(issue_valid), .issue_reg(issue_reg),
    .hazard1(h1[2]), .hazard2(h2[2]), .busy_vec(bv_c));

  assign bv[0] = bv_a;
  assign bv[1] = bv_b;
  assign bv[2] = {16'h0, bv_c};

  // Reference model state per configuration.
  int          depth_c [3] = '{32, 32, 16};
  bit          byp_c   [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_mem  [3][32];
  bit          m_busy [3][32];
  logic [31:0] m_d1 [3];
  logic [31:0] m_d2 [3];
  bit          m_h1 [3];
  bit          m_h2 [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        iv;
    logic [4:0]  ia;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eh1;
    logic        eh2;
  } vec_t;

  vec_t tbl [17];

  function automatic bit usable(int k, logic [4:0] a);
    return (int'(a) < depth_c[k]) && (a != 5'd0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i]  = 32'h0;
        m_busy[k][i] = 1'b0;
      end
      m_d1[k] = 32'h0; m_d2[k] = 32'h0; m_h1[k] = 1'b0; m_h2[k] = 1'b0;
    end
  endtask

  task automatic model_read(int k, logic [4:0] a, bit wv, output logic [31:0] d, output bit h);
    if (!usable(k, a)) begin
      d = 32'h0; h = 1'b0;
    end else if (byp_c[k] && wv && wr_reg == a) begin
      d = wr_data; h = 1'b0;
    end else begin
      d = m_mem[k][a]; h = m_busy[k][a];
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit wv;
      wv = reg_wr && usable(k, wr_reg);
      if (rd_en) begin
        model_read(k, re_reg1, wv, m_d1[k], m_h1[k]);
        model_read(k, re_reg2, wv, m_d2[k], m_h2[k]);
      end
      if (wv) begin
        m_mem[k][wr_reg]  = wr_data;
        m_busy[k][wr_reg] = 1'b0;
      end
      if (issue_valid && usable(k, issue_reg)) m_busy[k][issue_reg] = 1'b1;
    end
  endtask

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, k, act, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] ev;
      ev = 32'h0;
      for (int i = 0; i < depth_c[k]; i++) ev[i] = m_busy[k][i];
      chk({tag, ".re_data1"}, k, d1[k], m_d1[k]);
      chk({tag, ".re_data2"}, k, d2[k], m_d2[k]);
      chk({tag, ".hazard1"}, k, 32'(h1[k]), 32'(m_h1[k]));
      chk({tag, ".hazard2"}, k, 32'(h2[k]), 32'(m_h2[k]));
      chk({tag, ".busy_vec"}, k, bv[k], ev);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(logic wr, logic [4:0] wa, logic [31:0] wd, logic re,
                       logic [4:0] a1, logic [4:0] a2, logic iv, logic [4:0] ia);
    reg_wr = wr; wr_reg = wa; wr_data = wd; rd_en = re;
    re_reg1 = a1; re_reg2 = a2; issue_valid = iv; issue_reg = ia;
  endtask

  initial begin
    // {wr, wa, wd, re, a1, a2, iv, ia, exp d1, exp d2, exp h1, exp h2} for the default configuration
    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd1,  5'd2,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd5,  1'b0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  5'd5,  1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  1'b1, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    tbl[4]  = '{1'b1, 5'd7,  32'h1,        1'b1, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    tbl[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd7,  5'd7,  1'b0, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd7,  1'b1, 5'd3,  32'h0,        32'hA5A5A5A5, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b1};
    tbl[8]  = '{1'b1, 5'd3,  32'hCAFE0003, 1'b1, 5'd3,  5'd3,  1'b0, 5'd0,  32'hCAFE0003, 32'hCAFE0003, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd3,  5'd5,  1'b1, 5'd3,  32'h33,       32'hDEADBEEF, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd20, 1'b0, 5'd0,  32'h33,       32'h0,        1'b1, 1'b0};
    tbl[11] = '{1'b1, 5'd20, 32'h20202020, 1'b1, 5'd20, 5'd21, 1'b1, 5'd21, 32'h20202020, 32'h0,        1'b0, 1'b0};
    tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 5'd21, 1'b0, 5'd0,  32'h20202020, 32'h0,        1'b0, 1'b1};
    tbl[13] = '{1'b1, 5'd5,  32'h55,       1'b0, 5'd3,  5'd3,  1'b0, 5'd0,  32'h20202020, 32'h0,        1'b0, 1'b1};
    tbl[14] = '{1'b1, 5'd7,  32'h77,       1'b0, 5'd5,  5'd7,  1'b1, 5'd5,  32'h20202020, 32'h0,        1'b0, 1'b1};
    tbl[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd7,  1'b0, 5'd0,  32'h20202020, 32'h0,        1'b0, 1'b1};
    tbl[16] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd7,  1'b0, 5'd0,  32'h55,       32'h77,       1'b1, 1'b0};

    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    for (int r = 0; r < 17; r++) begin
      drive(tbl[r].wr, tbl[r].wa, tbl[r].wd, tbl[r].re, tbl[r].a1, tbl[r].a2, tbl[r].iv, tbl[r].ia);
      tick();
      chk($sformatf("tbl%0d.re_data1", r), 0, d1[0], tbl[r].e1);
      chk($sformatf("tbl%0d.re_data2", r), 0, d2[0], tbl[r].e2);
      chk($sformatf("tbl%0d.hazard1", r), 0, 32'(h1[0]), 32'(tbl[r].eh1));
      chk($sformatf("tbl%0d.hazard2", r), 0, 32'(h2[0]), 32'(tbl[r].eh2));
      check_all($sformatf("tbl%0d", r));
    end

    // Asynchronous reset between edges clears outputs with no clock edge.
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd5, 5'd7, 1'b1, 5'd9);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    check_all("reset_hold");
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd7, 1'b0, 5'd0);
    tick();
    check_all("post_reset_read");

    // Randomized traffic, biased toward a few registers to provoke hazards and forwarding.
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] a [4];
      for (int j = 0; j < 4; j++)
        a[j] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), a[0], $urandom, ($urandom_range(0, 9) < 8),
            a[1], a[2], 1'($urandom_range(0, 1)), a[3]);
      tick();
      check_all($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
